// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// width codes, fault causes and the request legality/alignment rules.
package lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LD_ISSUE  = 3'd1,
      S_LD_DATA   = 3'd2,
      S_ST_WRITE  = 3'd3,
      S_RMW_ISSUE = 3'd4,
      S_RMW_WRITE = 3'd5
   } lsu_state_e;

   typedef enum logic [1:0] {
      FC_NONE       = 2'b00,
      FC_MISALIGNED = 2'b01,
      FC_RANGE      = 2'b10,
      FC_ILLEGAL    = 2'b11
   } fault_cause_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned widths only exist for loads; stores accept B/H/W.
   function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store) return f3 inside {F3_B, F3_H, F3_W};
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   // Halves need an even address, words a multiple of four; bytes never fault.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      if (f3 == F3_H || f3 == F3_HU) return off[0];
      if (f3 == F3_W)                 return off != 2'b00;
      return 1'b0;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: extracts and extends a load result from the
// addressed memory word, and merges a byte/half store into the old word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rdata,
   input  logic [15:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [4:0]  shamt;
   logic [15:0] lane;
   logic [31:0] ins_mask;
   logic [31:0] ins_data;

   assign shamt = {byte_off, 3'b000};

   // Pick the 16 bits starting at the addressed byte (upper byte zero past the top lane).
   always_comb begin
      // NOTE: every combinational output gets a value on every path (here via
      // the case default) so synthesis never infers a latch.
      unique case (byte_off)
         2'd0:    lane = rdata[15:0];
         2'd1:    lane = rdata[23:8];
         2'd2:    lane = rdata[31:16];
         default: lane = {8'h00, rdata[31:24]};
      endcase
   end

   // Sign- or zero-extend the selected lane according to the access width.
   always_comb begin
      case (funct3)
         F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
         F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   load_data = {24'h000000, lane[7:0]};
         F3_HU:   load_data = {16'h0000, lane[15:0]};
         default: load_data = rdata;
      endcase
   end

   // Replace the target little-endian byte/half lane, keep the rest of the word.
   always_comb begin
      if (funct3 == F3_H) begin
         ins_mask = 32'h0000_FFFF << shamt;
         ins_data = {16'h0000, store_data} << shamt;
      end else begin
         ins_mask = 32'h0000_00FF << shamt;
         ins_data = {24'h000000, store_data[7:0]} << shamt;
      end
      merged_word = (rdata & ~ins_mask) | ins_data;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory with a
// one-cycle registered read. One request in flight; byte/half stores are
// done as read-modify-write; bad requests fault without touching memory.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned NUM_WORDS = 32
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   output logic [4:0]  resp_rd,
   output logic [31:0] resp_data,
   output logic        fault_valid,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr,
   output logic        mem_wr,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_e   state_q;
   logic [2:0]   funct3_q;
   logic [31:0]  addr_q;
   logic [31:0]  wdata_q;
   logic [4:0]   rd_q;
   logic         resp_valid_q;
   logic [4:0]   resp_rd_q;
   logic [31:0]  resp_data_q;
   logic         fault_valid_q;
   fault_cause_e fault_cause_q;
   logic [31:0]  fault_addr_q;

   fault_cause_e req_cause;
   logic [31:0]  load_data;
   logic [31:0]  merged_word;

   // Classify the incoming request; the first failing rule wins.
   always_comb begin
      req_cause = FC_NONE;
      if (!funct3_legal(req_is_store, req_funct3)) begin
         req_cause = FC_ILLEGAL;
      end else if (misaligned(req_funct3, req_addr[1:0])) begin
         req_cause = FC_MISALIGNED;
      end else if ({2'b00, req_addr[31:2]} >= NUM_WORDS) begin
         req_cause = FC_RANGE;
      end
   end

   lsu_align u_align (
      .funct3      (funct3_q),
      .byte_off    (addr_q[1:0]),
      .rdata       (mem_rdata),
      .store_data  (wdata_q[15:0]),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Request FSM with captured request fields and registered response/fault pulses.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= S_IDLE;
         funct3_q      <= 3'b000;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         rd_q          <= 5'd0;
         resp_valid_q  <= 1'b0;
         resp_rd_q     <= 5'd0;
         resp_data_q   <= 32'h0;
         fault_valid_q <= 1'b0;
         fault_cause_q <= FC_NONE;
         fault_addr_q  <= 32'h0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         resp_valid_q  <= 1'b0;
         fault_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  rd_q     <= req_rd;
                  if (req_cause != FC_NONE) begin
                     fault_valid_q <= 1'b1;
                     fault_cause_q <= req_cause;
                     fault_addr_q  <= req_addr;
                  end else if (!req_is_store) begin
                     state_q <= S_LD_ISSUE;
                  end else if (req_funct3 == F3_W) begin
                     state_q <= S_ST_WRITE;
                  end else begin
                     state_q <= S_RMW_ISSUE;
                  end
               end
            end
            S_LD_ISSUE:  state_q <= S_LD_DATA;
            S_LD_DATA: begin
               resp_valid_q <= 1'b1;
               resp_data_q  <= load_data;
               resp_rd_q    <= rd_q;
               state_q      <= S_IDLE;
            end
            S_ST_WRITE:  state_q <= S_IDLE;
            S_RMW_ISSUE: state_q <= S_RMW_WRITE;
            S_RMW_WRITE: state_q <= S_IDLE;
            default:     state_q <= S_IDLE;
         endcase
      end
   end

   // Memory pins decode from state and captured request only; idle means all zero.
   always_comb begin
      mem_read  = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      case (state_q)
         S_LD_ISSUE, S_RMW_ISSUE: begin
            mem_read = 1'b1;
            mem_addr = {addr_q[31:2], 2'b00};
         end
         S_ST_WRITE: begin
            mem_wr    = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = wdata_q;
         end
         S_RMW_WRITE: begin
            mem_wr    = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = merged_word;
         end
         default: ;
      endcase
   end

   assign req_ready   = (state_q == S_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_rd     = resp_rd_q;
   assign resp_data   = resp_data_q;
   assign fault_valid = fault_valid_q;
   assign fault_cause = fault_cause_q;
   assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// back-to-back and reset-abort sequences, then random traffic against a
// byte-array reference model of the data memory.
module tb_load_store_unit;

   localparam int NUM_WORDS = 32;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;
   logic        fault_valid;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;
   logic        mem_wr, mem_read;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   load_store_unit #(.NUM_WORDS(NUM_WORDS)) dut (
      .clk(clk), .n_rst(n_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
      .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr),
      .mem_wr(mem_wr), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- attached data memory (registered read) ----------------
   logic [31:0] mem [NUM_WORDS];
   logic [31:0] widx;
   assign widx = mem_addr >> 2;

   initial begin
      mem_rdata = 32'h0;
      for (int i = 0; i < NUM_WORDS; i++) mem[i] = 32'h0;
   end

   always @(posedge clk) begin
      if (mem_read && widx < NUM_WORDS) mem_rdata <= mem[widx[4:0]];
      if (mem_wr && widx < NUM_WORDS)   mem[widx[4:0]] <= mem_wdata;
   end

   // ---------------- monitors ----------------
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int overlap_cnt = 0;
   int wr_cnt = 0;
   int resp_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_wr) wr_cnt <= wr_cnt + 1;
   end

   always @(negedge clk) begin
      if (mem_read && mem_wr) overlap_cnt++;
      if (resp_valid) resp_q.push_back(cyc);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-addressed memory) ----------------
   logic [7:0] ref_mem [NUM_WORDS*4];

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [1:0] model_cause(input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      if (!legal) return 2'b11;
      if (a % size_of(f3) != 0) return 2'b01;
      if (a / 4 >= NUM_WORDS) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < size_of(f3); i++) v = v | (32'(ref_mem[7'(a + i)]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < size_of(f3); i++) ref_mem[7'(a + i)] = 8'(d >> (8 * i));
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      return model_load(3'd2, a & ~32'h3);
   endfunction

   // ---------------- transaction driver ----------------
   typedef struct {
      int          done_n;
      bit          got_resp;
      int          resp_n;
      logic [31:0] resp_data;
      logic [4:0]  resp_rd;
      bit          got_fault;
      logic [1:0]  f_cause;
      logic [31:0] f_addr;
      bit          saw_rd;
      bit          saw_wr;
      int          rd_n;
      int          wr_n;
      logic [31:0] wr_data;
      bit          addr_err;
   } obs_t;

   // Present one request at a negedge, then watch cycle by cycle (n counts
   // edges from the accept edge) until the unit is ready again.
   task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, output obs_t o);
      int w;
      o = '{done_n: 0, got_resp: 0, resp_n: 0, resp_data: 0, resp_rd: 0, got_fault: 0,
            f_cause: 0, f_addr: 0, saw_rd: 0, saw_wr: 0, rd_n: 0, wr_n: 0, wr_data: 0,
            addr_err: 0};
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_addr = a; req_wdata = d; req_rd = rd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (mem_read && !o.saw_rd) begin o.saw_rd = 1; o.rd_n = n; end
         if (mem_wr) begin o.saw_wr = 1; o.wr_n = n; o.wr_data = mem_wdata; end
         if ((mem_read || mem_wr) && mem_addr !== (a & ~32'h3)) o.addr_err = 1;
         if (resp_valid) begin
            o.got_resp = 1; o.resp_n = n; o.resp_data = resp_data; o.resp_rd = resp_rd;
         end
         if (fault_valid) begin
            o.got_fault = 1; o.f_cause = fault_cause; o.f_addr = fault_addr;
         end
         if (req_ready) begin
            o.done_n = n;
            break;
         end
      end
   endtask

   task automatic check_txn(input string tag, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [4:0] rd,
                            input logic [1:0] exp_cause, input logic [31:0] exp_val,
                            input obs_t o);
      int lat;
      lat = (exp_cause != 0) ? 1 : (!st ? 3 : (f3 == 3'd2 ? 2 : 3));
      check({tag, "_cycles_to_ready"}, o.done_n, lat);
      check({tag, "_fault_seen"}, o.got_fault, exp_cause != 0);
      if (exp_cause != 0) begin
         check({tag, "_fault_cause"}, o.f_cause, exp_cause);
         check({tag, "_fault_addr"}, o.f_addr, a);
         check({tag, "_fault_mem_idle"}, {o.saw_rd, o.saw_wr}, 0);
         check({tag, "_fault_no_resp"}, o.got_resp, 0);
      end else if (!st) begin
         check({tag, "_resp_seen"}, o.got_resp, 1);
         check({tag, "_resp_latency"}, o.resp_n, 3);
         check({tag, "_resp_data"}, o.resp_data, exp_val);
         check({tag, "_resp_rd"}, o.resp_rd, rd);
         check({tag, "_load_no_write"}, o.saw_wr, 0);
         check({tag, "_mem_addr"}, o.addr_err, 0);
      end else begin
         check({tag, "_store_wrote"}, o.saw_wr, 1);
         check({tag, "_store_wdata"}, o.wr_data, exp_val);
         check({tag, "_mem_addr"}, o.addr_err, 0);
         if (f3 == 3'd2) check({tag, "_sw_no_read"}, o.saw_rd, 0);
         else            check({tag, "_rmw_read_before_write"}, o.saw_rd && o.rd_n < o.wr_n, 1);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [1:0]  cause;
      logic [31:0] exp;   // load result, or memory write data for stores
   } vec_t;

   vec_t vecs[$];
   obs_t o, o2;

   initial begin
      // store/load sequence from an all-zero memory
      vecs.push_back('{1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF});
      vecs.push_back('{0, 3'b010, 32'h10, 32'h0,       5'd5,  2'b00, 32'hDEADBEEF});
      vecs.push_back('{1, 3'b000, 32'h11, 32'h0000007F, 5'd0, 2'b00, 32'hDEAD7FEF});
      vecs.push_back('{0, 3'b010, 32'h10, 32'h0,       5'd6,  2'b00, 32'hDEAD7FEF});
      vecs.push_back('{0, 3'b000, 32'h13, 32'h0,       5'd7,  2'b00, 32'hFFFFFFDE});
      vecs.push_back('{0, 3'b100, 32'h13, 32'h0,       5'd8,  2'b00, 32'h000000DE});
      vecs.push_back('{0, 3'b001, 32'h12, 32'h0,       5'd9,  2'b00, 32'hFFFFDEAD});
      vecs.push_back('{0, 3'b101, 32'h12, 32'h0,       5'd10, 2'b00, 32'h0000DEAD});
      vecs.push_back('{0, 3'b010, 32'h06, 32'h0,       5'd1,  2'b01, 32'h0});
      vecs.push_back('{0, 3'b010, 32'h80, 32'h0,       5'd1,  2'b10, 32'h0});
      vecs.push_back('{0, 3'b011, 32'h10, 32'h0,       5'd1,  2'b11, 32'h0});
      vecs.push_back('{0, 3'b010, 32'h7C, 32'h0,       5'd11, 2'b00, 32'h0});
      vecs.push_back('{1, 3'b001, 32'h16, 32'hABCD1234, 5'd0, 2'b00, 32'h12340000});
      vecs.push_back('{0, 3'b010, 32'h14, 32'h0,       5'd12, 2'b00, 32'h12340000});
      vecs.push_back('{0, 3'b001, 32'h15, 32'h0,       5'd1,  2'b01, 32'h0});
      vecs.push_back('{1, 3'b100, 32'h10, 32'h0,       5'd0,  2'b11, 32'h0});
      vecs.push_back('{0, 3'b011, 32'h06, 32'h0,       5'd1,  2'b11, 32'h0});
      vecs.push_back('{0, 3'b010, 32'h81, 32'h0,       5'd1,  2'b01, 32'h0});
      vecs.push_back('{0, 3'b000, 32'h80, 32'h0,       5'd1,  2'b10, 32'h0});
      vecs.push_back('{1, 3'b000, 32'h7F, 32'h000000A5, 5'd0, 2'b00, 32'hA5000000});
      vecs.push_back('{0, 3'b000, 32'h7F, 32'h0,       5'd31, 2'b00, 32'hFFFFFFA5});

      for (int i = 0; i < NUM_WORDS * 4; i++) ref_mem[i] = 8'h00;

      // ---- reset ----
      n_rst = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {31'(0), resp_valid} | {27'(0), resp_rd} | resp_data | {31'(0), fault_valid} |
            {30'(0), fault_cause} | fault_addr | mem_addr | mem_wdata |
            {30'(0), mem_read, mem_wr}, 32'h0);
      n_rst = 1'b1;
      @(negedge clk);
      check("reset_ready", req_ready, 1);
      check("reset_mem_idle", {mem_read, mem_wr}, 0);

      // ---- table ----
      foreach (vecs[i]) begin
         do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd, o);
         check_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr,
                   vecs[i].rd, vecs[i].cause, vecs[i].exp, o);
         if (vecs[i].st && vecs[i].cause == 0) model_store(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      end

      // ---- back-to-back loads: accepted in the cycle the first response pulses ----
      resp_q.delete();
      do_req(0, 3'b010, 32'h10, 32'h0, 5'd3, o);
      do_req(0, 3'b010, 32'h14, 32'h0, 5'd4, o2);
      check_txn("b2b_first", 0, 3'b010, 32'h10, 5'd3, 2'b00, 32'hDEAD7FEF, o);
      check_txn("b2b_second", 0, 3'b010, 32'h14, 5'd4, 2'b00, 32'h12340000, o2);
      check("b2b_pulse_count", resp_q.size(), 2);
      if (resp_q.size() == 2) check("b2b_pulse_spacing", resp_q[1] - resp_q[0], 3);

      // ---- reset during RMW_ISSUE of SB to 0x10 ----
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h10; req_wdata = 32'h00000055; req_rd = 5'd0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmw_abort_issue_read", {mem_read, mem_wr}, 2'b10);
      begin
         int wc;
         wc = wr_cnt;
         n_rst = 1'b0;
         #1;
         check("rmw_abort_mem_zero", {mem_read, mem_wr} | mem_addr | mem_wdata, 0);
         check("rmw_abort_ready", req_ready, 1);
         check("rmw_abort_pulses", {resp_valid, fault_valid}, 0);
         repeat (2) @(negedge clk);
         n_rst = 1'b1;
         @(negedge clk);
         check("rmw_abort_no_write", wr_cnt - wc, 0);
      end
      do_req(0, 3'b010, 32'h10, 32'h0, 5'd2, o);
      check_txn("rmw_abort_reload", 0, 3'b010, 32'h10, 5'd2, 2'b00, model_word(32'h10), o);

      // ---- random traffic against the reference model ----
      for (int k = 0; k < 300; k++) begin
         bit          st;
         logic [2:0]  f3;
         logic [31:0] a, d, exp_v;
         logic [4:0]  rd;
         logic [1:0]  cause;
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, 159));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
         if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
         d  = $urandom;
         rd = 5'($urandom_range(0, 31));
         cause = model_cause(st, f3, a);
         exp_v = 32'h0;
         if (cause == 0) begin
            if (st) begin
               model_store(f3, a, d);
               exp_v = model_word(a);
            end else begin
               exp_v = model_load(f3, a);
            end
         end
         do_req(st, f3, a, d, rd, o);
         check_txn($sformatf("rnd%0d", k), st, f3, a, rd, cause, exp_v, o);
      end

      check("mem_read_wr_overlap", overlap_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
